// File: rtl/hello_pkg.sv
// rtl/hello_pkg.sv - shared character codes, segment patterns and capture FSM states
//
// Purpose: constants shared by the HELLO display encoder side and the segment
//          capture side, so both agree on the code <-> pattern mapping.
// Ports:   none (package).

package hello_pkg;

  // 3-bit character codes as laid out on the switch bank
  localparam logic [2:0] CH_H     = 3'b000;
  localparam logic [2:0] CH_E     = 3'b001;
  localparam logic [2:0] CH_L     = 3'b010;
  localparam logic [2:0] CH_O     = 3'b011;
  localparam logic [2:0] CH_BLANK = 3'b111;

  // Active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_H     = 7'b0001001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Capture FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } cap_state_t;

endpackage

// File: rtl/seg_to_char.sv
// rtl/seg_to_char.sv - combinational 7-segment pattern to character code decoder
//
// Purpose: inverse of the display encoder for the five legal patterns; any other
//          pattern decodes to blank and raises bad.
// Ports:
//   seg   in  7  active-low pattern {g,f,e,d,c,b,a}
//   code  out 3  character code
//   bad   out 1  pattern was not one of the legal five

module seg_to_char
  import hello_pkg::*;
(
  input  logic [6:0] seg,
  output logic [2:0] code,
  output logic       bad
);

  always_comb begin
    code = CH_BLANK;
    bad  = 1'b0;
    case (seg)
      SEG_H:     code = CH_H;
      SEG_E:     code = CH_E;
      SEG_L:     code = CH_L;
      SEG_O:     code = CH_O;
      SEG_BLANK: code = CH_BLANK;
      default: begin
        // Unknown glyphs are shown as blank so the word layout is kept intact
        code = CH_BLANK;
        bad  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg_char_capture.sv
// rtl/seg_char_capture.sv - captures a stream of segment patterns into a packed character word
//
// Purpose: accepts active-low 7-segment patterns under a valid/ready handshake,
//          decodes each to a 3-bit code and shifts it into an 18-bit word (first
//          character ends up in [17:15]). A full word is presented with word_valid
//          until word_ack.
// Optional feature: macro SEG_ERR_COUNT_EN adds the err_cnt port, a saturating
//          count of accepted bad patterns cleared only by RESET.
// Ports:
//   CLOCK_50   in   1   clock, rising edge
//   RESET      in   1   synchronous active-high reset
//   seg_in     in   7   segment pattern {g,f,e,d,c,b,a}, active-low
//   seg_valid  in   1   seg_in valid
//   seg_ready  out  1   block accepts seg_in this cycle
//   word_ack   in   1   consumer has taken chars_out
//   chars_out  out  18  packed character codes
//   word_valid out  1   chars_out holds a complete word
//   bad_char   out  1   sticky bad-pattern flag for the current word
//   char_cnt   out  3   characters accepted in the current word
//   err_cnt    out  8   (SEG_ERR_COUNT_EN only) saturating bad-pattern count

module seg_char_capture
  import hello_pkg::*;
#(
  parameter int NUM_CHARS = 6,
  parameter int CHAR_W    = 3
) (
  input  logic                        CLOCK_50,
  input  logic                        RESET,
  input  logic [6:0]                  seg_in,
  input  logic                        seg_valid,
  output logic                        seg_ready,
  input  logic                        word_ack,
  output logic [NUM_CHARS*CHAR_W-1:0] chars_out,
  output logic                        word_valid,
  output logic                        bad_char,
  output logic [2:0]                  char_cnt
`ifdef SEG_ERR_COUNT_EN
  ,
  output logic [7:0]                  err_cnt
`endif
);

  localparam int WORD_W = NUM_CHARS * CHAR_W;

  cap_state_t state;
  logic [2:0] dec_code;
  logic       dec_bad;
  logic       xfer;

  seg_to_char u_dec (
    .seg  (seg_in),
    .code (dec_code),
    .bad  (dec_bad)
  );

  // seg_ready is a register that is only ever low in HOLD, so this is the
  // handshake for IDLE and FILL alike.
  assign xfer = seg_valid & seg_ready;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state      <= ST_IDLE;
      seg_ready  <= 1'b1;
      word_valid <= 1'b0;
      bad_char   <= 1'b0;
      char_cnt   <= 3'd0;
      chars_out  <= '1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            chars_out <= {chars_out[WORD_W-CHAR_W-1:0], dec_code};
            char_cnt  <= 3'd1;
            // New word: the previous word's flag is dropped here, not at ack,
            // so the consumer can still read it after acknowledging.
            bad_char  <= dec_bad;
            state     <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (xfer) begin
            chars_out <= {chars_out[WORD_W-CHAR_W-1:0], dec_code};
            char_cnt  <= char_cnt + 3'd1;
            bad_char  <= bad_char | dec_bad;
            if (char_cnt == 3'(NUM_CHARS - 1)) begin
              state      <= ST_HOLD;
              seg_ready  <= 1'b0;
              word_valid <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (word_ack) begin
            state      <= ST_IDLE;
            seg_ready  <= 1'b1;
            word_valid <= 1'b0;
            char_cnt   <= 3'd0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          seg_ready  <= 1'b1;
          word_valid <= 1'b0;
          char_cnt   <= 3'd0;
        end
      endcase
    end
  end

`ifdef SEG_ERR_COUNT_EN
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      err_cnt <= 8'd0;
    end else if (xfer && dec_bad && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seg_char_capture.sv
// tb/tb_seg_char_capture.sv - directed self-checking bench for seg_char_capture

module tb_seg_char_capture;

  logic        CLOCK_50;
  logic        RESET;
  logic [6:0]  seg_in;
  logic        seg_valid;
  logic        seg_ready;
  logic        word_ack;
  logic [17:0] chars_out;
  logic        word_valid;
  logic        bad_char;
  logic [2:0]  char_cnt;
`ifdef SEG_ERR_COUNT_EN
  logic [7:0]  err_cnt;
`endif

  int n_checks;
  int n_errors;

  localparam logic [6:0] P_H   = 7'b0001001;
  localparam logic [6:0] P_E   = 7'b0000110;
  localparam logic [6:0] P_L   = 7'b1000111;
  localparam logic [6:0] P_O   = 7'b1000000;
  localparam logic [6:0] P_BL  = 7'b1111111;
  localparam logic [6:0] P_BAD = 7'b0101010;

  seg_char_capture dut (
    .CLOCK_50   (CLOCK_50),
    .RESET      (RESET),
    .seg_in     (seg_in),
    .seg_valid  (seg_valid),
    .seg_ready  (seg_ready),
    .word_ack   (word_ack),
    .chars_out  (chars_out),
    .word_valid (word_valid),
    .bad_char   (bad_char),
    .char_cnt   (char_cnt)
`ifdef SEG_ERR_COUNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send(input logic [6:0] p);
    seg_in    = p;
    seg_valid = 1'b1;
    tick();
    seg_valid = 1'b0;
  endtask

  task automatic ack();
    word_ack = 1'b1;
    tick();
    word_ack = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_chars"}, 32'(chars_out), 32'h3FFFF);
    check({tag, "_wvalid"}, 32'(word_valid), 32'd0);
    check({tag, "_ready"}, 32'(seg_ready), 32'd1);
    check({tag, "_cnt"}, 32'(char_cnt), 32'd0);
    check({tag, "_bad"}, 32'(bad_char), 32'd0);
`ifdef SEG_ERR_COUNT_EN
    check({tag, "_errcnt"}, 32'(err_cnt), 32'd0);
`endif
  endtask

  initial begin
    logic [17:0] held;
    n_checks  = 0;
    n_errors  = 0;
    RESET     = 1'b1;
    seg_in    = 7'd0;
    seg_valid = 1'b0;
    word_ack  = 1'b0;

    // 1: reset held for two cycles
    tick();
    tick();
    RESET = 1'b0;
    check_reset_state("reset");

    // 2: HELLO + blank back-to-back
    send(P_H);
    check("w1_cnt1", 32'(char_cnt), 32'd1);
    send(P_E);
    send(P_L);
    send(P_L);
    send(P_O);
    check("w1_cnt5", 32'(char_cnt), 32'd5);
    check("w1_wvalid_early", 32'(word_valid), 32'd0);
    send(P_BL);
    check("w1_wvalid", 32'(word_valid), 32'd1);
    check("w1_cnt6", 32'(char_cnt), 32'd6);
    check("w1_chars", 32'(chars_out), 32'(18'b000_001_010_010_011_111));
    check("w1_bad", 32'(bad_char), 32'd0);

    // 3: HOLD ignores seg_valid; ack returns to IDLE with data kept
    held      = chars_out;
    seg_in    = P_E;
    seg_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_ready", 32'(seg_ready), 32'd0);
      check("hold_chars", 32'(chars_out), 32'(held));
    end
    word_ack = 1'b1;
    tick();
    word_ack  = 1'b0;
    seg_valid = 1'b0;
    check("ack_wvalid", 32'(word_valid), 32'd0);
    check("ack_cnt", 32'(char_cnt), 32'd0);
    check("ack_ready", 32'(seg_ready), 32'd1);
    check("ack_chars_kept", 32'(chars_out), 32'(held));
    // ack outside HOLD does nothing
    ack();
    check("idle_ack_cnt", 32'(char_cnt), 32'd0);
    check("idle_ack_ready", 32'(seg_ready), 32'd1);

    // 4: bad pattern in slot 1
    send(P_H);
    send(P_BAD);
    check("w2_bad_early", 32'(bad_char), 32'd1);
    send(P_L);
    send(P_L);
    send(P_O);
    send(P_BL);
    check("w2_wvalid", 32'(word_valid), 32'd1);
    check("w2_chars", 32'(chars_out), 32'(18'b000_111_010_010_011_111));
    check("w2_bad", 32'(bad_char), 32'd1);
`ifdef SEG_ERR_COUNT_EN
    check("w2_errcnt", 32'(err_cnt), 32'd1);
`endif
    ack();
    check("w2_bad_kept", 32'(bad_char), 32'd1);
    send(P_H);
    check("w3_bad_cleared", 32'(bad_char), 32'd0);
    check("w3_cnt1", 32'(char_cnt), 32'd1);

    // 5: reset after three transfers, with seg_valid also high
    send(P_E);
    send(P_L);
    check("w3_cnt3", 32'(char_cnt), 32'd3);
    RESET     = 1'b1;
    seg_in    = P_O;
    seg_valid = 1'b1;
    tick();
    RESET     = 1'b0;
    seg_valid = 1'b0;
    check_reset_state("midrst");
    send(P_O);
    send(P_L);
    send(P_E);
    send(P_H);
    send(P_BL);
    check("w4_wvalid_early", 32'(word_valid), 32'd0);
    send(P_O);
    check("w4_wvalid", 32'(word_valid), 32'd1);
    check("w4_chars", 32'(chars_out), 32'(18'b011_010_001_000_111_011));
    check("w4_bad", 32'(bad_char), 32'd0);
    ack();

    // All-bad word decodes to all blank and flags bad
    for (int i = 0; i < 6; i++) send(7'b0000000);
    check("w5_chars", 32'(chars_out), 32'h3FFFF);
    check("w5_bad", 32'(bad_char), 32'd1);
    ack();

`ifdef SEG_ERR_COUNT_EN
    // 6: 300 bad patterns total (6 above + 294 here) saturate the counter
    for (int w = 0; w < 49; w++) begin
      for (int i = 0; i < 6; i++) send(P_BAD);
      ack();
    end
    check("sat_errcnt", 32'(err_cnt), 32'hFF);
    for (int i = 0; i < 6; i++) send(P_BAD);
    ack();
    check("sat_errcnt_stays", 32'(err_cnt), 32'hFF);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
